// File: rtl/keypad_scanner_pkg.sv
// Shared types, constants and helpers for the 4x4 keypad scanner.
package keypad_scanner_pkg;

  localparam int KEY_W = 4;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;

  localparam logic [COLS-1:0] COL_IDLE = 4'b1111;

  // Debounce FSM states
  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_PRESS_DEB   = 2'd1,
    ST_HELD        = 2'd2,
    ST_RELEASE_DEB = 2'd3
  } deb_state_t;

  // Frame classification codes
  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_SINGLE = 2'd1,
    CLS_MULTI  = 2'd2
  } key_class_t;

  typedef struct packed {
    key_class_t       cls;
    logic [KEY_W-1:0] key;
  } classify_t;

  // Classify a full-frame snapshot: no key, exactly one key (with its code), or several.
  function automatic classify_t classify(input logic [ROWS*COLS-1:0] snap);
    classify_t  res;
    logic [4:0] n;
    n       = 5'd0;
    res.key = {KEY_W{1'b0}};
    res.cls = CLS_NONE;
    for (int i = 0; i < ROWS*COLS; i++) begin
      if (snap[i]) begin
        n       = n + 5'd1;
        res.key = KEY_W'(i);
      end else begin
        n = n;
      end
    end
    case (n)
      5'd0:    res.cls = CLS_NONE;
      5'd1:    res.cls = CLS_SINGLE;
      default: res.cls = CLS_MULTI;
    endcase
    return res;
  endfunction

  // Active-low one-hot column drive for a column index.
  function automatic logic [COLS-1:0] col_drive(input logic [1:0] idx);
    logic [COLS-1:0] one;
    one = 4'b0001;
    return ~(one << idx);
  endfunction

endpackage

// File: rtl/keypad_col_scanner.sv
// Column sequencer: dwells SCAN_DIV cycles on each column, flags the
// sampling cycle of each column and the end of a full 4-column frame.
module keypad_col_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Enable,
  output logic [3:0]  o_Col,
  output logic [1:0]  o_Col_Idx,
  output logic        o_Sample,
  output logic        o_Frame
);

  localparam int            DW         = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

  logic          r_run;
  logic [DW-1:0] r_dwell;
  logic [1:0]    r_idx;
  logic [3:0]    r_col;
  logic          w_last;

  // Rows are sampled on the last dwell cycle so they have settled for SCAN_DIV-1 cycles.
  assign w_last    = r_run && (r_dwell == DWELL_LAST);
  assign o_Sample  = w_last;
  assign o_Frame   = w_last && (r_idx == 2'd3);
  assign o_Col     = r_col;
  assign o_Col_Idx = r_idx;

  // Dwell counter, column index and registered column drive.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_run   <= 1'b0;
      r_dwell <= '0;
      r_idx   <= 2'd0;
      r_col   <= COL_IDLE;
    end else if (!i_Enable) begin
      r_run   <= 1'b0;
      r_dwell <= '0;
      r_idx   <= 2'd0;
      r_col   <= COL_IDLE;
    end else if (!r_run) begin
      // First driven cycle always starts on column 0
      r_run   <= 1'b1;
      r_dwell <= '0;
      r_idx   <= 2'd0;
      r_col   <= col_drive(2'd0);
    end else if (w_last) begin
      // Column index wraps 3 -> 0 on purpose
      r_dwell <= '0;
      r_idx   <= r_idx + 2'd1;
      r_col   <= col_drive(r_idx + 2'd1);
    end else begin
      r_dwell <= r_dwell + DW'(1);
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: synchronizes rows, builds a per-frame
// snapshot, classifies it and debounces presses/releases frame by frame.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Enable,
  input  logic [ROWS-1:0]   i_Row,
  output logic [COLS-1:0]   o_Col,
  output logic [KEY_W-1:0]  o_Key,
  output logic              o_fKey,
  output logic              o_Held,
  output logic              o_Multi
);

  localparam int            CW      = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CNT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [ROWS-1:0]      r_row_meta;
  logic [ROWS-1:0]      r_row_sync;
  logic [ROWS*COLS-1:0] r_snap;
  deb_state_t           r_state;
  logic [KEY_W-1:0]     r_cand;
  logic [CW-1:0]        r_cnt;
  logic [KEY_W-1:0]     r_key;
  logic                 r_fkey;
  logic                 r_held;
  logic                 r_multi;

  logic [ROWS-1:0]      w_rows;
  logic [1:0]           w_col_idx;
  logic                 w_sample;
  logic                 w_frame;
  logic [ROWS*COLS-1:0] w_snap_next;
  classify_t            w_cls;
  logic                 w_single_cand;
  logic [CW-1:0]        w_cnt_inc;

  keypad_col_scanner #(
    .SCAN_DIV (SCAN_DIV)
  ) u_col_scanner (
    .i_Clk     (i_Clk),
    .i_Rst     (i_Rst),
    .i_Enable  (i_Enable),
    .o_Col     (o_Col),
    .o_Col_Idx (w_col_idx),
    .o_Sample  (w_sample),
    .o_Frame   (w_frame)
  );

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_row_meta <= 4'b1111;
      r_row_sync <= 4'b1111;
    end else begin
      r_row_meta <= i_Row;
      r_row_sync <= r_row_meta;
    end
  end

  assign w_rows = ~r_row_sync;

  // Snapshot as it will look after this cycle's sample, so the frame strobe sees column 3 too.
  always_comb begin
    w_snap_next = r_snap;
    if (w_sample) begin
      w_snap_next[{w_col_idx, 2'b00} +: ROWS] = w_rows;
    end else begin
      w_snap_next = r_snap;
    end
  end

  assign w_cls         = classify(w_snap_next);
  assign w_single_cand = (w_cls.cls == CLS_SINGLE) && (w_cls.key == r_cand);
  assign w_cnt_inc     = (r_cnt == CNT_MAX) ? CNT_MAX : (r_cnt + CNT_ONE);

  // Snapshot register: one nibble per column, cleared while disabled.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_snap <= '0;
    end else if (!i_Enable) begin
      r_snap <= '0;
    end else if (w_sample) begin
      r_snap <= w_snap_next;
    end else begin
      r_snap <= r_snap;
    end
  end

  // Debounce FSM with registered key/strobe/held/multi outputs, stepped once per frame.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_state <= ST_IDLE;
      r_cand  <= '0;
      r_cnt   <= '0;
      r_key   <= '0;
      r_fkey  <= 1'b0;
      r_held  <= 1'b0;
      r_multi <= 1'b0;
    end else if (!i_Enable) begin
      // Disable wins over a coinciding acceptance; the last key code is kept
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_fkey  <= 1'b0;
      r_held  <= 1'b0;
      r_multi <= 1'b0;
    end else begin
      r_fkey <= 1'b0;
      if (w_frame) begin
        r_multi <= (w_cls.cls == CLS_MULTI);
        case (r_state)
          ST_IDLE: begin
            if (w_cls.cls == CLS_SINGLE) begin
              r_cand  <= w_cls.key;
              r_cnt   <= CNT_ONE;
              r_state <= ST_PRESS_DEB;
            end else begin
              r_cnt <= '0;
            end
          end
          ST_PRESS_DEB: begin
            if (w_single_cand) begin
              if (w_cnt_inc == CNT_MAX) begin
                r_state <= ST_HELD;
                r_cnt   <= '0;
                r_key   <= r_cand;
                r_held  <= 1'b1;
                r_fkey  <= 1'b1;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end else begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end
          end
          ST_HELD: begin
            if (w_single_cand) begin
              r_cnt <= '0;
            end else begin
              r_state <= ST_RELEASE_DEB;
              r_cnt   <= CNT_ONE;
            end
          end
          ST_RELEASE_DEB: begin
            if (w_single_cand) begin
              r_state <= ST_HELD;
              r_cnt   <= '0;
            end else if (w_cnt_inc == CNT_MAX) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
              r_held  <= 1'b0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_held  <= 1'b0;
          end
        endcase
      end else begin
        r_state <= r_state;
      end
    end
  end

  assign o_Key   = r_key;
  assign o_fKey  = r_fkey;
  assign o_Held  = r_held;
  assign o_Multi = r_multi;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a frame-level reference model
// predicts press strobes, key code, held and multi flags per frame.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [3:0]  row;
  logic [3:0]  o_Col;
  logic [3:0]  o_Key;
  logic        o_fKey;
  logic        o_Held;
  logic        o_Multi;

  logic [15:0] mask;
  logic [3:0]  col_d;

  typedef struct {
    bit         fkey;
    logic [3:0] key;
    bit         held;
    bit         multi;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (frame level)
  bit         m_free;
  int         m_run_key;
  int         m_run_len;
  int         m_held_key;
  int         m_miss;
  logic [3:0] m_last_key;

  bit          pend_v;
  logic [15:0] pend_mask;

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEB)
  ) dut (
    .i_Clk    (clk),
    .i_Rst    (rst_n),
    .i_Enable (en),
    .i_Row    (row),
    .o_Col    (o_Col),
    .o_Key    (o_Key),
    .o_fKey   (o_fKey),
    .o_Held   (o_Held),
    .o_Multi  (o_Multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key matrix: a pressed key pulls its row low while its column is driven
  always_comb begin
    row = 4'b1111;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (o_Col[c] == 1'b0 && mask[c*4+r]) row[r] = 1'b0;
  end

  always @(posedge clk) col_d <= o_Col;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic model_reset(input bit clr_key);
    m_free    = 1'b1;
    m_run_len = 0;
    m_run_key = 0;
    m_miss    = 0;
    pend_v    = 1'b0;
    if (clr_key) m_last_key = 4'd0;
  endtask

  // One completed frame with the given set of pressed keys
  task automatic model_step(input logic [15:0] m, output exp_t e);
    int n;
    int k;
    bit single;
    n = $countones(m);
    k = 0;
    for (int i = 0; i < 16; i++) if (m[i]) k = i;
    single  = (n == 1);
    e.fkey  = 1'b0;
    e.multi = (n >= 2);
    if (m_free) begin
      if (single && m_run_len > 0 && k == m_run_key) m_run_len++;
      else if (m_run_len > 0) m_run_len = 0;
      else if (single) begin m_run_key = k; m_run_len = 1; end
      if (m_run_len == DEB) begin
        e.fkey     = 1'b1;
        m_last_key = 4'(k);
        m_held_key = k;
        m_free     = 1'b0;
        m_miss     = 0;
        m_run_len  = 0;
      end
    end else begin
      if (single && k == m_held_key) m_miss = 0;
      else m_miss++;
      if (m_miss == DEB) begin
        m_free    = 1'b1;
        m_run_len = 0;
      end
    end
    e.held = !m_free;
    e.key  = m_last_key;
  endtask

  task automatic wait_frame_start();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (o_Col == 4'b1110 && col_d != 4'b1110) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL frame_timeout: no frame start seen, o_Col=%b", o_Col);
  endtask

  // Apply a key set for one whole frame; the previous frame's prediction is queued now
  task automatic run_frame(input logic [15:0] m);
    exp_t e;
    wait_frame_start();
    if (pend_v) begin
      model_step(pend_mask, e);
      exp_q.push_back(e);
    end
    mask      = m;
    pend_mask = m;
    pend_v    = 1'b1;
  endtask

  task automatic run_n(input logic [15:0] m, input int n);
    for (int i = 0; i < n; i++) run_frame(m);
  endtask

  // Monitor: compares at every frame start; strobes anywhere else are errors
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && o_Col == 4'b1110 && col_d != 4'b1110 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("fkey",  {15'd0, o_fKey},  {15'd0, e.fkey});
      chk("key",   {12'd0, o_Key},   {12'd0, e.key});
      chk("held",  {15'd0, o_Held},  {15'd0, e.held});
      chk("multi", {15'd0, o_Multi}, {15'd0, e.multi});
    end else if (o_fKey) begin
      n_checks++;
      n_fail++;
      $display("FAIL stray_fkey: got 1 expected 0 at %0t", $time);
    end
  end

  initial begin
    logic [3:0]  one;
    logic [15:0] bit1;
    int          frames;
    one  = 4'b0001;
    bit1 = 16'h0001;
    mask = 16'h0000;
    en   = 1'b0;
    rst_n = 1'b0;
    model_reset(1'b1);

    // 1. reset values, then the column sequence after enable
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_col",   {12'd0, o_Col}, 16'h000f);
    chk("rst_key",   {12'd0, o_Key}, 16'h0000);
    chk("rst_flags", {13'd0, o_fKey, o_Held, o_Multi}, 16'h0000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_col", {12'd0, o_Col}, 16'h000f);
    en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      chk("scan_col", {12'd0, o_Col}, {12'd0, ~(one << (i / 4))});
      chk("scan_flags", {13'd0, o_fKey, o_Held, o_Multi}, 16'h0000);
    end

    // 2. key 6 pressed steadily, then released
    run_n(bit1 << 6, 5);
    run_n(16'h0000, 5);
    // 3. key 9 bouncing every other frame
    for (int i = 0; i < 8; i++) run_frame((i % 2 == 0) ? (bit1 << 9) : 16'h0000);
    // 4. keys 2 and 13 together, then 13 released, then 2 released
    run_n((bit1 << 2) | (bit1 << 13), 5);
    run_n(bit1 << 2, 5);
    run_n(16'h0000, 5);
    // 5. key 15 with a single-frame dropout
    run_n(bit1 << 15, 5);
    run_frame(16'h0000);
    run_n(bit1 << 15, 3);
    run_n(16'h0000, 5);

    // Random runs of single keys, empty frames and multi-key frames
    frames = 0;
    while (frames < 120) begin
      int sel;
      int len;
      logic [15:0] m;
      sel = $urandom_range(0, 9);
      if (sel < 5) begin
        m   = bit1 << $urandom_range(0, 15);
        len = $urandom_range(1, 6);
      end else if (sel < 7) begin
        m   = 16'h0000;
        len = $urandom_range(1, 4);
      end else begin
        m   = (bit1 << $urandom_range(0, 15)) | (bit1 << $urandom_range(0, 15));
        len = $urandom_range(1, 3);
      end
      run_n(m, len);
      frames += len;
    end

    // 6a. disable mid-PRESS_DEB
    run_n(16'h0000, DEB + 1);
    run_n(bit1 << 5, 2);
    repeat (6) @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk); #1;
    chk("dis_col",   {12'd0, o_Col}, 16'h000f);
    chk("dis_flags", {13'd0, o_fKey, o_Held, o_Multi}, 16'h0000);
    chk("dis_key",   {12'd0, o_Key}, {12'd0, m_last_key});
    model_reset(1'b0);
    repeat (48) @(posedge clk);
    mask = 16'h0000;
    @(negedge clk);
    en = 1'b1;

    // 6b. disable in the same cycle as an acceptance: no pulse
    run_n(16'h0000, DEB + 1);
    run_n(bit1 << 3, 3);
    repeat (15) @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk); #1;
    chk("race_fkey", {15'd0, o_fKey}, 16'h0000);
    chk("race_held", {15'd0, o_Held}, 16'h0000);
    chk("race_col",  {12'd0, o_Col}, 16'h000f);
    chk("race_key",  {12'd0, o_Key}, {12'd0, m_last_key});
    model_reset(1'b0);
    repeat (20) @(posedge clk);
    mask = 16'h0000;
    @(negedge clk);
    en = 1'b1;

    // 6c. asynchronous reset while HELD
    run_n(bit1 << 12, 5);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_held", {15'd0, o_Held}, 16'h0001);
    rst_n = 1'b0;
    #1;
    chk("arst_col",   {12'd0, o_Col}, 16'h000f);
    chk("arst_key",   {12'd0, o_Key}, 16'h0000);
    chk("arst_flags", {13'd0, o_fKey, o_Held, o_Multi}, 16'h0000);
    model_reset(1'b1);
    repeat (3) @(posedge clk);
    chk("queue_drained", 16'(exp_q.size()), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
